// File: rtl/eb_credit_rx_pkg.sv
// Shared sizing helpers for the credit-link receiver.
// Covers the occupancy/pointer widths and the legal DEPTH range.
package eb_credit_rx_pkg;

    localparam int EB_DEPTH_MIN = 2;
    localparam int EB_DEPTH_MAX = 64;

    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int pw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= EB_DEPTH_MIN) && (depth <= EB_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/eb_credit_rx_if.sv
// Link-side push port, downstream valid/ready port and status outputs of eb_credit_rx.
interface eb_credit_rx_if
    import eb_credit_rx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = cw_of(DEPTH);

    logic             t_0_valid;
    logic [WIDTH-1:0] t_0_data;
    logic             i_0_valid;
    logic [WIDTH-1:0] i_0_data;
    logic             i_0_ready;
    logic             credit_return;
    logic             overflow;
    logic [CW-1:0]    level;

    modport master (
        output t_0_valid, t_0_data, i_0_ready,
        input  i_0_valid, i_0_data, credit_return, overflow, level
    );

    modport slave (
        input  t_0_valid, t_0_data, i_0_ready,
        output i_0_valid, i_0_data, credit_return, overflow, level
    );

endinterface

// File: rtl/eb_credit_rx_regfile_1w1r.sv
// Beat storage: WIDTH x DEPTH flop array, one synchronous write port, one async read port.
module eb_regfile_1w1r #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/eb_credit_rx.sv
// Credit-link sink: buffers pushed beats, drains them valid/ready, returns one credit per drain.
// Optional macro EB_CREDIT_RX_BYPASS_EN enables the zero-latency empty-FIFO bypass.
module eb_credit_rx
    import eb_credit_rx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    eb_credit_rx_if.slave link
);

    localparam int CW = cw_of(DEPTH);
    localparam int PW = pw_of(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] level_t;

    localparam ptr_t   PTR_LAST   = ptr_t'(DEPTH - 1);
    localparam level_t LEVEL_FULL = level_t'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_depth_check
        $error("eb_credit_rx: DEPTH outside supported range");
    end

    ptr_t             rd_ptr;
    ptr_t             wr_ptr;
    level_t           level_q;
    logic             credit_q;
    logic             overflow_q;
    logic [WIDTH-1:0] rd_data;

    logic push;
    logic empty;
    logic full;
    logic pop_fifo;
    logic byp_take;
    logic pop_any;
    logic push_acc;

    assign push     = link.t_0_valid;
    assign empty    = (level_q == '0);
    assign full     = (level_q == LEVEL_FULL);
    assign pop_fifo = !empty && link.i_0_ready;

`ifdef EB_CREDIT_RX_BYPASS_EN
    assign byp_take       = empty && push && link.i_0_ready;
    assign link.i_0_valid = !empty || push;
    assign link.i_0_data  = empty ? link.t_0_data : rd_data;
`else
    assign byp_take       = 1'b0;
    assign link.i_0_valid = !empty;
    assign link.i_0_data  = rd_data;
`endif

    // A bypassed beat is consumed in flight and must not also land in storage.
    assign pop_any  = pop_fifo || byp_take;
    assign push_acc = push && (!full || pop_fifo) && !byp_take;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + ptr_t'(1);
    endfunction

    eb_regfile_1w1r #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_regfile (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr),
        .wdata (link.t_0_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_fifo) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            level_q  <= level_q + level_t'(push_acc) - level_t'(pop_fifo);
            credit_q <= pop_any;
            if (push && full && !pop_fifo) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign link.credit_return = credit_q;
    assign link.overflow      = overflow_q;
    assign link.level         = level_q;

endmodule

// File: tb/tb_eb_credit_rx.sv
// Directed bench for eb_credit_rx: DEPTH=4 and DEPTH=3 instances, both bypass build options.
module tb_eb_credit_rx;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    eb_credit_rx_if #(.WIDTH(32), .DEPTH(4)) if4 ();
    eb_credit_rx_if #(.WIDTH(32), .DEPTH(3)) if3 ();

    eb_credit_rx #(.WIDTH(32), .DEPTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .link  (if4.slave)
    );

    eb_credit_rx #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .link  (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] beats [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        if4.t_0_valid = 1'b0; if4.t_0_data = '0; if4.i_0_ready = 1'b0;
        if3.t_0_valid = 1'b0; if3.t_0_data = '0; if3.i_0_ready = 1'b0;
        #12;
        chk("rst_level", 32'(if4.level), 32'd0);
        chk("rst_valid", 32'(if4.i_0_valid), 32'd0);
        chk("rst_credit", 32'(if4.credit_return), 32'd0);
        chk("rst_overflow", 32'(if4.overflow), 32'd0);
        reset = 1'b0;
        tick();

        // 1: fill four beats with no downstream accept
        beats[0] = 32'h11; beats[1] = 32'h22; beats[2] = 32'h33; beats[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin
            if4.t_0_valid = 1'b1;
            if4.t_0_data  = beats[i];
            tick();
            chk("fill_level", 32'(if4.level), 32'(i + 1));
            chk("fill_head", if4.i_0_data, 32'h11);
        end
        if4.t_0_valid = 1'b0;
        #1;
        chk("full_valid", 32'(if4.i_0_valid), 32'd1);
        chk("full_credit", 32'(if4.credit_return), 32'd0);
        chk("full_overflow", 32'(if4.overflow), 32'd0);

        // 2: drain in order, one credit per pop
        if4.i_0_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_data", if4.i_0_data, beats[k]);
            tick();
            chk("drain_credit", 32'(if4.credit_return), 32'd1);
            chk("drain_level", 32'(if4.level), 32'(3 - k));
        end
        if4.i_0_ready = 1'b0;
        tick();
        chk("idle_credit", 32'(if4.credit_return), 32'd0);
        chk("idle_valid", 32'(if4.i_0_valid), 32'd0);

        // 3: full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            if4.t_0_valid = 1'b1;
            if4.t_0_data  = 32'h51 + 32'(i);
            tick();
        end
        chk("fill2_level", 32'(if4.level), 32'd4);
        if4.t_0_data  = 32'h55;
        if4.i_0_ready = 1'b1;
        #1;
        chk("pp_head", if4.i_0_data, 32'h51);
        tick();
        chk("pp_level", 32'(if4.level), 32'd4);
        chk("pp_overflow", 32'(if4.overflow), 32'd0);
        chk("pp_credit", 32'(if4.credit_return), 32'd1);
        if4.t_0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("pp_drain", if4.i_0_data, 32'h52 + 32'(k));
            tick();
        end
        chk("pp_empty", 32'(if4.level), 32'd0);
        if4.i_0_ready = 1'b0;
        tick();

        // 4: push into a full FIFO with no pop is dropped and flagged
        for (int i = 0; i < 4; i++) begin
            if4.t_0_valid = 1'b1;
            if4.t_0_data  = 32'h61 + 32'(i);
            tick();
        end
        if4.t_0_data = 32'h66;
        tick();
        chk("ovf_set", 32'(if4.overflow), 32'd1);
        chk("ovf_level", 32'(if4.level), 32'd4);
        chk("ovf_credit", 32'(if4.credit_return), 32'd0);
        if4.t_0_valid = 1'b0;
        tick();
        chk("ovf_sticky", 32'(if4.overflow), 32'd1);
        if4.i_0_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ovf_drain", if4.i_0_data, 32'h61 + 32'(k));
            tick();
        end
        #1;
        chk("ovf_empty_valid", 32'(if4.i_0_valid), 32'd0);
        chk("ovf_still", 32'(if4.overflow), 32'd1);
        if4.i_0_ready = 1'b0;
        tick();

        // 6: push into empty FIFO with downstream ready
        if4.t_0_valid = 1'b1;
        if4.t_0_data  = 32'hA5;
        if4.i_0_ready = 1'b1;
        #1;
`ifdef EB_CREDIT_RX_BYPASS_EN
        chk("byp_valid", 32'(if4.i_0_valid), 32'd1);
        chk("byp_data", if4.i_0_data, 32'hA5);
        tick();
        if4.t_0_valid = 1'b0;
        #1;
        chk("byp_level", 32'(if4.level), 32'd0);
        chk("byp_credit", 32'(if4.credit_return), 32'd1);
        chk("byp_after_valid", 32'(if4.i_0_valid), 32'd0);
`else
        chk("nobyp_valid0", 32'(if4.i_0_valid), 32'd0);
        tick();
        if4.t_0_valid = 1'b0;
        #1;
        chk("nobyp_valid1", 32'(if4.i_0_valid), 32'd1);
        chk("nobyp_data", if4.i_0_data, 32'hA5);
        chk("nobyp_level", 32'(if4.level), 32'd1);
        chk("nobyp_credit0", 32'(if4.credit_return), 32'd0);
        tick();
        chk("nobyp_credit1", 32'(if4.credit_return), 32'd1);
        chk("nobyp_level0", 32'(if4.level), 32'd0);
`endif
        if4.i_0_ready = 1'b0;
        tick();

        // 5: DEPTH=3 continuous push and pop, pointers wrap repeatedly
        if3.t_0_valid = 1'b1;
        if3.i_0_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if3.t_0_data = 32'h100 + 32'(k);
            #1;
`ifdef EB_CREDIT_RX_BYPASS_EN
            chk("d3_valid", 32'(if3.i_0_valid), 32'd1);
            chk("d3_data", if3.i_0_data, 32'h100 + 32'(k));
            chk("d3_level", 32'(if3.level), 32'd0);
            chk("d3_credit", 32'(if3.credit_return), (k >= 1) ? 32'd1 : 32'd0);
`else
            chk("d3_valid", 32'(if3.i_0_valid), (k >= 1) ? 32'd1 : 32'd0);
            if (k >= 1) begin
                chk("d3_data", if3.i_0_data, 32'h100 + 32'(k - 1));
            end
            chk("d3_level", 32'(if3.level), (k >= 1) ? 32'd1 : 32'd0);
            chk("d3_credit", 32'(if3.credit_return), (k >= 2) ? 32'd1 : 32'd0);
`endif
            tick();
        end
        if3.t_0_valid = 1'b0;
        tick();
        tick();
        if3.i_0_ready = 1'b0;
        #1;
        chk("d3_end_level", 32'(if3.level), 32'd0);
        chk("d3_end_valid", 32'(if3.i_0_valid), 32'd0);

        // Reset mid-operation discards buffered beats and clears overflow
        if4.t_0_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if4.t_0_data = 32'h71 + 32'(i);
            tick();
        end
        if4.t_0_valid = 1'b0;
        chk("pre_rst_level", 32'(if4.level), 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_rst_level", 32'(if4.level), 32'd0);
        chk("mid_rst_valid", 32'(if4.i_0_valid), 32'd0);
        chk("mid_rst_overflow", 32'(if4.overflow), 32'd0);
        tick();
        reset = 1'b0;
        if4.i_0_ready = 1'b1;
        tick();
        chk("post_rst_credit", 32'(if4.credit_return), 32'd0);
        chk("post_rst_level", 32'(if4.level), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
